// File: rtl/uart_beep_sched.sv
// uart_beep_sched: shares one buzzer between three UART event sources.
// Requester i plays i+1 beeps (rx byte = 1, tx done = 2, frame error = 3).
// Requests are level flags that are synchronized and edge-detected. Each
// requester queues at most one pending event. Grants are non-preemptive,
// and bit 2 has the highest priority.
//
// Ports:
//   sys_clk   in   clock
//   sys_rst   in   asynchronous reset, active-low
//   req       in   [2:0] level request flags, async; rising edge = event
//   mute      in   forces beep_en low; sequencing is unaffected
//   clear     in   synchronous flush of pending requests and active pattern
//   beep_en   out  registered buzzer drive
//   busy      out  high whenever the sequencer is not idle
//   grant     out  [2:0] one-hot owner of the active pattern, 0 when idle
//   overflow  out  one-cycle pulse when an event coalesces into a pending one
module uart_beep_sched #(
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned ON_CYCLES  = 5000000,
    parameter int unsigned OFF_CYCLES = 2500000,
    parameter int unsigned GAP_CYCLES = 10000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] req,
    input  logic       mute,
    input  logic       clear,
    output logic       beep_en,
    output logic       busy,
    output logic [2:0] grant,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       beep_left_q, beep_left_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       s0_q, s1_q, s2_q;
    logic             beep_en_q, beep_en_d;
    logic             overflow_q, overflow_d;
    logic [2:0]       rise;
    logic [2:0]       pick;
    logic [1:0]       pick_beeps;
    logic [2:0]       pend_clr;

    assign rise = s1_q & ~s2_q;

    // Highest set pending bit wins; its beep count is index + 1.
    always_comb begin
        pick       = 3'b000;
        pick_beeps = 2'd0;
        if (pending_q[2]) begin
            pick       = 3'b100;
            pick_beeps = 2'd3;
        end else if (pending_q[1]) begin
            pick       = 3'b010;
            pick_beeps = 2'd2;
        end else if (pending_q[0]) begin
            pick       = 3'b001;
            pick_beeps = 2'd1;
        end
    end

    // State register, plus the input synchronizer and the datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            beep_left_q <= 2'd0;
            grant_q     <= 3'b000;
            pending_q   <= 3'b000;
            s0_q        <= 3'b000;
            s1_q        <= 3'b000;
            s2_q        <= 3'b000;
            beep_en_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beep_left_q <= beep_left_d;
            grant_q     <= grant_d;
            pending_q   <= pending_d;
            s0_q        <= req;
            s1_q        <= s0_q;
            s2_q        <= s1_q;
            beep_en_q   <= beep_en_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beep_left_d = beep_left_q;
        grant_d     = grant_q;
        pend_clr    = 3'b000;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    grant_d     = pick;
                    beep_left_d = pick_beeps;
                    pend_clr    = pick;
                    cnt_d       = '0;
                    state_d     = StOn;
                end
            end
            StOn: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = '0;
                    state_d = (beep_left_q > 2'd1) ? StOff : StGap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StOff: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d       = '0;
                    beep_left_d = beep_left_q - 2'd1;
                    state_d     = StOn;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    grant_d = 3'b000;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        // A new rise beats the grant-clear of the same bit, so it re-queues.
        pending_d = (pending_q & ~pend_clr) | rise;

        if (clear) begin
            state_d     = StIdle;
            cnt_d       = '0;
            beep_left_d = 2'd0;
            grant_d     = 3'b000;
            pending_d   = 3'b000;
        end
    end

    // Output logic; beep_en is registered off the next state.
    always_comb begin
        beep_en_d  = (state_d == StOn) && !mute;
        overflow_d = !clear && |(rise & pending_q);
    end

    assign beep_en  = beep_en_q;
    assign overflow = overflow_q;
    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_beep_sched.sv
module tb_uart_beep_sched;

    localparam int unsigned CNT_W = 8;
    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int GAP = 3;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [2:0] req     = 3'b000;
    logic       mute    = 1'b0;
    logic       clear   = 1'b0;
    logic       beep_en, busy, overflow;
    logic [2:0] grant;

    uart_beep_sched #(
        .CNT_W     (CNT_W),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .GAP_CYCLES(GAP)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .mute    (mute),
        .clear   (clear),
        .beep_en (beep_en),
        .busy    (busy),
        .grant   (grant),
        .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       beep;
        logic       busy;
        logic [2:0] grant;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 0;

    // Reference model: pattern owner, start edge and pending flags; outputs
    // come from the offset into the pattern using plain arithmetic.
    logic [2:0] m_pend;
    int         m_owner;
    int         m_start;
    int         m_edge;
    logic [2:0] h1, h2, h3;  // req as sampled 1, 2 and 3 edges ago

    function automatic void model_reset();
        m_pend  = 3'b000;
        m_owner = -1;
        m_start = 0;
        m_edge  = 0;
        h1      = 3'b000;
        h2      = 3'b000;
        h3      = 3'b000;
    endfunction

    function automatic int pat_len(input int owner);
        int k;
        k = owner + 1;
        return k * ON + (k - 1) * OFF + GAP;
    endfunction

    // Predict the outputs after the coming clock edge with the present inputs.
    function automatic exp_t model_step();
        exp_t       e;
        logic [2:0] rise;
        int         k, off, win;
        rise = h2 & ~h3;
        m_edge++;
        e.ovf = !clear && ((rise & m_pend) != 3'b000);
        if (clear) begin
            m_owner = -1;
            m_pend  = 3'b000;
        end else begin
            if (m_owner < 0) begin
                if (m_pend != 3'b000) begin
                    m_owner = m_pend[2] ? 2 : (m_pend[1] ? 1 : 0);
                    m_start = m_edge;
                    m_pend[m_owner] = 1'b0;
                end
            end else if (m_edge - m_start >= pat_len(m_owner)) begin
                m_owner = -1;
            end
            m_pend = m_pend | rise;
        end
        h3 = h2;
        h2 = h1;
        h1 = req;
        e.busy  = (m_owner >= 0);
        e.grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        e.beep  = 1'b0;
        if (m_owner >= 0 && !mute) begin
            k   = m_owner + 1;
            off = m_edge - m_start;
            win = k * ON + (k - 1) * OFF;
            e.beep = (off < win) && ((off % (ON + OFF)) < ON);
        end
        return e;
    endfunction

    // Monitor: one scoreboard entry per clock edge, compared mid-cycle.
    always @(negedge sys_clk) begin
        exp_t e, act;
        if (mon_en) begin
            vectors++;
            act = {beep_en, busy, grant, overflow};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t got=%b", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got beep/busy/grant/ovf=%b want=%b",
                             $time, act, e);
                end
            end
        end
    end

    task automatic tick();
        exp_t e;
        e = model_step();
        @(posedge sys_clk);
        exp_q.push_back(e);
        mon_en = 1;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({beep_en, busy, grant, overflow} !== 6'b0) begin
            miscompares++;
            $display("FAIL %s got=%b want=000000", tag, {beep_en, busy, grant, overflow});
        end
    endtask

    // Asynchronous reset applied between edges, checked before any clock edge.
    task automatic do_reset();
        @(negedge sys_clk);
        #1;
        mon_en  = 0;
        sys_rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_reset_outputs("power_on_reset");
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;

        // 1: single beep from a held level
        req = 3'b001; run(20);
        req = 3'b000; run(4);
        // 2: three-beep pattern
        req = 3'b100; run(30);
        req = 3'b000; run(3);
        // 3: simultaneous rises, priority order
        req = 3'b101; run(45);
        req = 3'b000; run(3);
        // 4: repeated pulses during an active pattern
        req = 3'b010; run(2); req = 3'b000; run(5);
        req = 3'b010; run(2); req = 3'b000; run(2);
        req = 3'b010; run(2); req = 3'b000; run(3);
        req = 3'b010; run(2); req = 3'b000; run(40);
        // 5: mute over a three-beep pattern, then clear mid-ON
        mute = 1'b1; req = 3'b100; run(25);
        mute = 1'b0; req = 3'b000; run(3);
        req = 3'b001; run(5);
        clear = 1'b1; run(1);
        clear = 1'b0; run(15);
        req = 3'b000; run(3);
        // 6: reset during an OFF phase, then fresh latency
        req = 3'b100; run(3); req = 3'b000; run(6);
        do_reset();
        run(3);
        req = 3'b001; run(15);
        req = 3'b000; run(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) req[$urandom_range(0, 2)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) mute = ~mute;
            clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 799) == 0) begin
                clear = 1'b0;
                do_reset();
            end
            tick();
        end
        clear = 1'b0;
        run(2);

        @(negedge sys_clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d entries want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
